registro_serializador: RTL and testbench
========================================

# registro_serializador

Parallel-to-serial transmitter for the register datapath. It accepts a `REGISTRO_WIDTH`-bit word from the `FlipFlopD` register output through a load handshake. It shifts the word out MSB-first on a single serial line, with a configurable bit period and an optional parity bit. It is the outbound end of the register interface: the register stores words, and this block reads them out and sends them off-chip.

## Interface
Parameters:
- `REGISTRO_WIDTH`, default 4: word width in bits (≥2).
- `DIV`, default 1: clock cycles per serial bit (≥1).

Ports:
- `CLK`: input, 1 bit. Single clock; all logic on the rising edge.
- `RST`: input, 1 bit. Reset is synchronous and active-low; sampled only on the `CLK` rising edge.
- `D`: input, `REGISTRO_WIDTH` bits. Parallel word, normally driven from `FlipFlopD.Q`.
- `EN`: input, 1 bit. Load request; qualified by `LISTO`.
- `LISTO`: output, 1 bit. Ready to accept a word.
- `SER`: output, 1 bit. Serial data; idles high.
- `SER_VAL`: output, 1 bit. High while `SER` carries a data or parity bit.
- `FRAME`: output, 1 bit. High during the first bit period (MSB) only.
- `FIN`: output, 1 bit. One-cycle pulse after the last bit of a frame.

## Operation
- States: `IDLE`, `SHIFT`, `PARIDAD` (only with the macro), `DONE`.
- Reset values (`RST`=0 at an edge): state `IDLE`, `LISTO`=1, `SER`=1, `SER_VAL`=0, `FRAME`=0, `FIN`=0. Shift register, bit counter and prescaler all clear to 0.
- Reset wins over every other event. Reset mid-frame aborts the frame with no `FIN` pulse.
- `IDLE`:
  - `LISTO`=1.
  - If `EN`=1 at an edge, capture `D` into the shift register. Load bit counter = `REGISTRO_WIDTH`-1 and prescaler = 0, then go to `SHIFT`.
  - If `EN`=0, stay in `IDLE`.
- `SHIFT`:
  - `SER` = current MSB of the shift register, `SER_VAL`=1, `LISTO`=0.
  - Prescaler counts 0..`DIV`-1. On wrap, shift left one bit and decrement the bit counter.
  - After bit 0 completes, go to `PARIDAD` if the macro is defined, else `DONE`.
- `PARIDAD`: holds `SER` = even-parity bit (XOR of the captured word) for `DIV` cycles, with `SER_VAL`=1, then goes to `DONE`.
- `DONE`: one cycle with `SER`=1, `SER_VAL`=0, `FIN`=1, `LISTO`=0, then unconditionally back to `IDLE`.
- `EN` while `LISTO`=0 is ignored; there is no queuing, and `D` changes during a frame have no effect.
- Captured word is frozen at the load edge.
- Prescaler and bit counter are sized `$clog2` of their ranges. `DIV`=1 means the prescaler is always 0 and the block shifts every cycle.

## Timing
- Load edge t0 (`EN`=1, `LISTO`=1).
- Cycles after t0:
  - t0+1: `SER`=D[W-1], `FRAME`=1, `SER_VAL`=1, `LISTO`=0.
  - Data bit k (MSB = k 0) occupies cycles t0+1+k·`DIV` .. t0+(k+1)·`DIV`.
  - `FRAME` is high for exactly `DIV` cycles.
  - Parity bit, if enabled, occupies the next `DIV` cycles.
  - `DONE` and `FIN` fall at t0+`W`·`DIV`+1 (+`DIV` with parity).
  - `LISTO` returns 1 in the following cycle.
- Minimum word period: `W`·`DIV`+2 cycles (+`DIV` with parity). Back-to-back loads hold `EN`=1 continuously.
- Load-to-first-bit latency: 1 cycle.

## Configuration
- Macro: `REGISTRO_SERIALIZADOR_PARIDAD_EN`.
- Defined: the `PARIDAD` state is compiled in and an even-parity bit follows bit 0 for `DIV` cycles.
- Undefined: the state and XOR logic are absent, and `SHIFT` goes directly to `DONE`.
- Port list is identical in both builds.

## Test plan
- Reset: hold `RST`=0 for 3 edges with `EN`=1 and `D`=4'hF. Required: `LISTO`=1, `SER`=1, `SER_VAL`=0 and `FIN`=0 throughout; no frame starts.
- Basic frame (`W`=4, `DIV`=1, no parity): `D`=4'b1011, `EN` pulse. Required: `SER`=1,0,1,1 on t0+1..t0+4; `FRAME` high only at t0+1; `FIN` at t0+5; `LISTO` back at t0+6.
- Prescaler (`DIV`=3): `D`=4'b0110. Required: each bit held 3 cycles (`SER`=0×3, 1×3, 1×3, 0×3); `FRAME` high 3 cycles; `FIN` at t0+13.
- Parity (macro defined, `DIV`=1): `D`=4'b1011 gives a parity bit of 1 at t0+5 and `FIN` at t0+6. `D`=4'b1001 gives a parity bit of 0.
- Busy/back-to-back: `EN` held 1 while `D` increments by 1 every cycle. Required: only words sampled when `LISTO`=1 are sent, successive frames start every 6 cycles, and mid-frame `D` changes never appear on `SER`.
- Reset mid-frame: drive `RST`=0 at t0+2. Required: next cycle `SER`=1, `SER_VAL`=0, `LISTO`=1, no `FIN` pulse; a new load afterwards transmits correctly.

Source files
------------

// File: rtl/registro_serializador.sv
// MSB-first parallel-to-serial transmitter with load handshake and DIV-cycle bit period.
// Optional even-parity bit enabled by defining REGISTRO_SERIALIZADOR_PARIDAD_EN.
module registro_serializador #(
    parameter int REGISTRO_WIDTH = 4,
    parameter int DIV            = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [REGISTRO_WIDTH-1:0] D,
    input  logic                      EN,
    output logic                      LISTO,
    output logic                      SER,
    output logic                      SER_VAL,
    output logic                      FRAME,
    output logic                      FIN
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(REGISTRO_WIDTH);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] BIT_FIRST  = CW'(REGISTRO_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
        PARIDAD,
`endif
        DONE
    } state_t;

    state_t                    state;
    // SER holds the bit on the line; shreg holds the bits still queued behind it.
    logic [REGISTRO_WIDTH-2:0] shreg;
    logic [PW-1:0]             presc;
    logic [CW-1:0]             bcnt;
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
    logic                      par;
`endif

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state   <= IDLE;
            shreg   <= '0;
            presc   <= '0;
            bcnt    <= '0;
            LISTO   <= 1'b1;
            SER     <= 1'b1;
            SER_VAL <= 1'b0;
            FRAME   <= 1'b0;
            FIN     <= 1'b0;
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    LISTO   <= 1'b1;
                    SER     <= 1'b1;
                    SER_VAL <= 1'b0;
                    FRAME   <= 1'b0;
                    FIN     <= 1'b0;
                    if (EN) begin
                        state   <= SHIFT;
                        shreg   <= D[REGISTRO_WIDTH-2:0];
                        bcnt    <= BIT_FIRST;
                        presc   <= '0;
                        SER     <= D[REGISTRO_WIDTH-1];
                        SER_VAL <= 1'b1;
                        FRAME   <= 1'b1;
                        LISTO   <= 1'b0;
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
                        par     <= ^D;
`endif
                    end
                end

                SHIFT: begin
                    if (presc == PRESC_LAST) begin
                        presc <= '0;
                        FRAME <= 1'b0;
                        if (bcnt == '0) begin
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
                            state <= PARIDAD;
                            SER   <= par;
`else
                            state   <= DONE;
                            SER     <= 1'b1;
                            SER_VAL <= 1'b0;
                            FIN     <= 1'b1;
`endif
                        end else begin
                            SER   <= shreg[REGISTRO_WIDTH-2];
                            shreg <= shreg << 1;
                            bcnt  <= bcnt - 1'b1;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end

`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
                PARIDAD: begin
                    if (presc == PRESC_LAST) begin
                        presc   <= '0;
                        state   <= DONE;
                        SER     <= 1'b1;
                        SER_VAL <= 1'b0;
                        FIN     <= 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                    FIN   <= 1'b0;
                    LISTO <= 1'b1;
                end

                default: begin
                    state   <= IDLE;
                    LISTO   <= 1'b1;
                    SER     <= 1'b1;
                    SER_VAL <= 1'b0;
                    FRAME   <= 1'b0;
                    FIN     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_registro_serializador.sv
// Scoreboard bench: two instances (DIV=1, DIV=3) share stimulus; a frame-level model
// predicts every cycle's outputs and a negedge monitor compares them.
module tb_registro_serializador;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] d;

    logic listo0, ser0, ser_val0, frame0, fin0;
    logic listo1, ser1, ser_val1, frame1, fin1;

    // {SER, SER_VAL, FRAME, FIN, LISTO}
    typedef logic [4:0] out_t;
    localparam out_t IDLE_O = 5'b10001;

    out_t fut [2][$];
    out_t sb  [2][$];
    out_t cur [2];

    int checks = 0;
    int passes = 0;
    int cyc    = 0;

    registro_serializador #(.REGISTRO_WIDTH(W), .DIV(1)) dut0 (
        .CLK(clk), .RST(rst), .D(d), .EN(en),
        .LISTO(listo0), .SER(ser0), .SER_VAL(ser_val0), .FRAME(frame0), .FIN(fin0)
    );

    registro_serializador #(.REGISTRO_WIDTH(W), .DIV(3)) dut1 (
        .CLK(clk), .RST(rst), .D(d), .EN(en),
        .LISTO(listo1), .SER(ser1), .SER_VAL(ser_val1), .FRAME(frame1), .FIN(fin1)
    );

    always #5 clk = ~clk;

    // Predicts the outputs visible after the coming edge, given the inputs now applied.
    task automatic model(input int i, input int div);
        out_t o;
        if (!rst) begin
            fut[i].delete();
            o = IDLE_O;
        end else if (cur[i][0] && en) begin
            fut[i].delete();
            for (int k = W - 1; k >= 0; k--)
                for (int c = 0; c < div; c++)
                    fut[i].push_back({d[k], 1'b1, (k == W - 1), 1'b0, 1'b0});
`ifdef REGISTRO_SERIALIZADOR_PARIDAD_EN
            for (int c = 0; c < div; c++)
                fut[i].push_back({^d, 1'b1, 1'b0, 1'b0, 1'b0});
`endif
            fut[i].push_back(5'b10010);
            o = fut[i].pop_front();
        end else if (fut[i].size() > 0) begin
            o = fut[i].pop_front();
        end else begin
            o = IDLE_O;
        end
        cur[i] = o;
        sb[i].push_back(o);
    endtask

    task automatic step(input logic r, input logic e, input logic [W-1:0] dv);
        rst = r;
        en  = e;
        d   = dv;
        model(0, 1);
        model(1, 3);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (sb[i].size() > 0) begin
                out_t e;
                out_t a;
                e = sb[i].pop_front();
                a = (i == 0) ? {ser0, ser_val0, frame0, fin0, listo0}
                             : {ser1, ser_val1, frame1, fin1, listo1};
                checks++;
                if (a !== e)
                    $display("FAIL out_inst%0d cycle %0d: got {ser,val,frame,fin,listo}=%b expected %b",
                             i, cyc, a, e);
                else
                    passes++;
            end
        end
    end

    initial begin
        cur[0] = IDLE_O;
        cur[1] = IDLE_O;

        // Reset held with a pending load request
        repeat (3) step(1'b0, 1'b1, 4'hF);

        // Basic frame and prescaled frame
        step(1'b1, 1'b1, 4'b1011);
        repeat (20) step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b0110);
        repeat (20) step(1'b1, 1'b0, 4'b1111);
        step(1'b1, 1'b1, 4'b1001);
        repeat (20) step(1'b1, 1'b0, 4'b0101);

        // Back-to-back loads while D increments every cycle
        for (int n = 0; n < 40; n++)
            step(1'b1, 1'b1, W'(n));
        repeat (20) step(1'b1, 1'b0, 4'b0000);

        // Reset two cycles into a frame, then a clean frame
        step(1'b1, 1'b1, 4'b1101);
        step(1'b1, 1'b0, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        step(1'b1, 1'b0, 4'b0000);
        step(1'b1, 1'b1, 4'b1010);
        repeat (20) step(1'b1, 1'b0, 4'b0000);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++)
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0), W'($urandom));

        repeat (20) step(1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        #1;

        checks++;
        if (sb[0].size() != 0 || sb[1].size() != 0)
            $display("FAIL drain: got %0d/%0d pending expectations expected 0/0",
                     sb[0].size(), sb[1].size());
        else
            passes++;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
